// File: rtl/mem_access_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// MEM-stage controller that sits between the EX/MEM and MEM/WB pipeline
// registers. It turns the EX/MEM access code, byte address and store data into
// a single word-aligned request/acknowledge transaction on the data-memory bus.
// While that transaction is in flight it stalls the front of the pipeline. It
// returns sign- or zero-extended load data for the MEM/WB stage.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-high reset
//   en            global enable; gates launching a request and leaving DONE
//   dmem_access   4-bit access code (none, lb, lh, lw, lbu, lhu, sb, sh, sw)
//   addr          byte address from EX/MEM
//   st_data       store data from EX/MEM
//   bus_req       registered bus request, held until bus_ack
//   bus_we        registered write enable
//   bus_addr      registered word address {addr[31:2], 2'b00}
//   bus_wdata     registered store data, replicated across byte lanes
//   bus_wstrb     registered byte strobes (0000 for loads)
//   bus_ack       bus transaction complete
//   bus_rdata     read word, valid together with bus_ack
//   dmem_rd_out   registered, extended load data (0 for stores and aborts)
//   mem_stall     combinational stall to PC/IF-ID/ID-EX/EX-MEM, flush to MEM/WB
//   misalign_err  combinational flag: valid access with a misaligned address
//   timeout_err   one-cycle pulse after an access is aborted for lack of ack
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  dmem_access,
    input  logic [31:0] addr,
    input  logic [31:0] st_data,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [31:0] dmem_rd_out,
    output logic        mem_stall,
    output logic        misalign_err,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_t;

    // A zero TIMEOUT disables the abort path entirely.
    localparam bit               TO_ENABLE = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t           state, state_next;
    logic [CNT_W-1:0] to_cnt;
    logic [2:0]       ld_type;
    logic [1:0]       ld_off;

    logic acc_valid;
    logic misaligned;
    logic launch;
    logic ack_take;
    logic abort;

    // Lane-replicated store data so the memory can pick any enabled lane.
    function automatic logic [31:0] store_wdata(input logic [1:0]  size,
                                                input logic [31:0] sd);
        case (size)
            2'b01:   store_wdata = {4{sd[7:0]}};
            2'b10:   store_wdata = {2{sd[15:0]}};
            default: store_wdata = sd;
        endcase
    endfunction

    function automatic logic [3:0] store_wstrb(input logic [3:0] code,
                                               input logic [1:0] off);
        case (code)
            4'b1001: store_wstrb = 4'b0001 << off;
            4'b1010: store_wstrb = off[1] ? 4'b1100 : 4'b0011;
            4'b1011: store_wstrb = 4'b1111;
            default: store_wstrb = 4'b0000;
        endcase
    endfunction

    // Selects the addressed byte/half of the read word and extends it.
    function automatic logic [31:0] load_ext(input logic [2:0]  typ,
                                             input logic [1:0]  off,
                                             input logic [31:0] rdata);
        logic signed [7:0]  byte_s;
        logic signed [15:0] half_s;
        byte_s = rdata[8*off +: 8];
        half_s = off[1] ? rdata[31:16] : rdata[15:0];
        case (typ)
            3'b001:  load_ext = 32'(byte_s);
            3'b010:  load_ext = 32'(half_s);
            3'b011:  load_ext = rdata;
            3'b100:  load_ext = {24'd0, byte_s};
            3'b101:  load_ext = {16'd0, half_s};
            default: load_ext = 32'd0;
        endcase
    endfunction

    // Access decode: unknown codes behave like "none".
    always_comb begin
        acc_valid  = 1'b0;
        misaligned = 1'b0;
        case (dmem_access)
            4'b0001, 4'b0100: acc_valid = 1'b1;
            4'b0010, 4'b0101, 4'b1010: begin
                acc_valid  = 1'b1;
                misaligned = addr[0];
            end
            4'b0011, 4'b1011: begin
                acc_valid  = 1'b1;
                misaligned = (addr[1:0] != 2'b00);
            end
            4'b1001: acc_valid = 1'b1;
            default: ;
        endcase
    end

    assign misalign_err = acc_valid && misaligned;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mem_stall  = 1'b0;
        launch     = 1'b0;
        ack_take   = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                // Stall is raised as soon as a launchable access is present,
                // even while en holds the launch back.
                if (acc_valid && !misaligned) begin
                    mem_stall = 1'b1;
                    if (en) begin
                        launch     = 1'b1;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                // en is deliberately ignored here: an issued transaction
                // always runs to ack or abort.
                mem_stall = 1'b1;
                if (bus_ack) begin
                    ack_take   = 1'b1;
                    state_next = DONE;
                end else if (TO_ENABLE && (to_cnt == TO_LAST)) begin
                    abort      = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (en) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= 32'd0;
            bus_wdata   <= 32'd0;
            bus_wstrb   <= 4'd0;
            dmem_rd_out <= 32'd0;
            timeout_err <= 1'b0;
            to_cnt      <= '0;
            ld_type     <= 3'd0;
            ld_off      <= 2'd0;
        end else begin
            timeout_err <= abort;
            if (launch) begin
                bus_req   <= 1'b1;
                bus_we    <= dmem_access[3];
                bus_addr  <= {addr[31:2], 2'b00};
                bus_wdata <= store_wdata(dmem_access[1:0], st_data);
                bus_wstrb <= store_wstrb(dmem_access, addr[1:0]);
                ld_type   <= dmem_access[2:0];
                ld_off    <= addr[1:0];
                to_cnt    <= '0;
            end else if (ack_take) begin
                bus_req     <= 1'b0;
                dmem_rd_out <= bus_we ? 32'd0 : load_ext(ld_type, ld_off, bus_rdata);
            end else if (abort) begin
                bus_req     <= 1'b0;
                dmem_rd_out <= 32'd0;
            end else if (state == WAIT) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

endmodule
